rf_write_arbiter: RTL and testbench

Two-requester write-port arbiter for the single-write-port register file in the NPC core. It collects write-back requests from EXU (port A) and LSU (port B), buffers one entry per port, and drives the RF `wen`/`waddr`/`wdata` inputs with at most one write per cycle. Writes to x0 are filtered here, so the RF never sees them. Ordering between the two ports is oldest-first, with round-robin to break ties.

---
 rtl/rf_write_arbiter_if.sv | 30 +++
 rtl/rf_write_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Bus interface for rf_write_arbiter. It carries the two write-back request
// ports (A = EXU, B = LSU), the register-file write port and the idle flag.
// master: the requesters and RF side (testbench / core); slave: the arbiter.
interface rf_write_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  idle;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_wen, rf_waddr, rf_wdata, idle
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_wen, rf_waddr, rf_wdata, idle
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester write-port arbiter for a single-write-port
// register file. Each port buffers one entry. Writes to x0 are dropped at
// acceptance. Entries are written oldest-first. A round-robin pointer breaks
// ties between entries loaded in the same cycle.
// Optional feature macro: RF_ARB_PERF_EN adds the perf_writes/perf_stalls
// counters.
module rf_write_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_write_arbiter_if.slave    bus
`ifdef RF_ARB_PERF_EN
  ,
  output logic [31:0]          perf_writes,
  output logic [31:0]          perf_stalls
`endif
);

  // Per-port buffered entry
  logic                  r_held_a, r_held_b;
  logic [ADDR_WIDTH-1:0] r_addr_a, r_addr_b;
  logic [DATA_WIDTH-1:0] r_data_a, r_data_b;
  // Ordering state
  logic                  r_a_older;  // A was loaded before B
  logic                  r_tie;      // both entries were loaded in the same cycle
  logic                  r_rr;       // 0: A wins the next tie, 1: B wins it

  logic w_grant_a, w_grant_b;
  logic w_acc_a, w_acc_b;
  logic w_load_a, w_load_b;
  logic w_keep_a, w_keep_b;
  logic w_both_held;

  assign w_both_held = r_held_a & r_held_b;

  // Grant selection from registered state only, so ready never depends on valid
  always_comb begin
    // NOTE: defaults first so every path assigns both grants; this prevents latch inference.
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (w_both_held) begin
      if (r_tie) begin
        w_grant_a = ~r_rr;
        w_grant_b = r_rr;
      end else begin
        w_grant_a = r_a_older;
        w_grant_b = ~r_a_older;
      end
    end else begin
      w_grant_a = r_held_a;
      w_grant_b = r_held_b;
    end
  end

  // A port accepts when its slot is empty or is being drained this cycle
  assign bus.a_ready = ~r_held_a | w_grant_a;
  assign bus.b_ready = ~r_held_b | w_grant_b;

  assign w_acc_a  = bus.a_valid & bus.a_ready;
  assign w_acc_b  = bus.b_valid & bus.b_ready;
  // x0 writes complete the handshake but never occupy the slot
  assign w_load_a = w_acc_a & (bus.a_addr != '0);
  assign w_load_b = w_acc_b & (bus.b_addr != '0);
  // An entry that is held and not written this cycle survives into the next one
  assign w_keep_a = r_held_a & ~w_grant_a;
  assign w_keep_b = r_held_b & ~w_grant_b;

  assign bus.rf_wen   = w_grant_a | w_grant_b;
  assign bus.rf_waddr = w_grant_a ? r_addr_a : r_addr_b;
  assign bus.rf_wdata = w_grant_a ? r_data_a : r_data_b;
  assign bus.idle     = ~r_held_a & ~r_held_b;

  // Control state: occupancy, age and tie-break pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      r_held_a  <= 1'b0;
      r_held_b  <= 1'b0;
      r_a_older <= 1'b0;
      r_tie     <= 1'b0;
      r_rr      <= 1'b0;
    end else begin
      r_held_a <= w_load_a | w_keep_a;
      r_held_b <= w_load_b | w_keep_b;
      r_tie    <= w_load_a & w_load_b;
      if (w_load_a && !w_load_b && w_keep_b) begin
        r_a_older <= 1'b0;
      end else if (w_load_b && !w_load_a && w_keep_a) begin
        r_a_older <= 1'b1;
      end
      if (w_both_held && r_tie) begin
        r_rr <= ~r_rr;
      end
    end
  end

  // Entry payload registers, loaded on acceptance
  // NOTE: payload flops have no reset; they are only read while the matching held bit is set.
  always_ff @(posedge clk) begin
    if (w_load_a) begin
      r_addr_a <= bus.a_addr;
      r_data_a <= bus.a_data;
    end
    if (w_load_b) begin
      r_addr_b <= bus.b_addr;
      r_data_b <= bus.b_data;
    end
  end

`ifdef RF_ARB_PERF_EN
  // Performance counters: completed writes and cycles with both slots occupied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (bus.rf_wen) begin
        perf_writes <= perf_writes + 32'd1;
      end
      if (w_both_held) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. A scoreboard queue holds the
// expected RF writes in order. The monitor pops and compares one entry on
// every cycle where rf_wen is high. Directed steps check ready/idle/wen at
// specific cycles.
module tb_rf_write_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  wr_t  sb_q[$];

  rf_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef RF_ARB_PERF_EN
  logic [31:0] perf_writes;
  logic [31:0] perf_stalls;
`endif

  rf_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef RF_ARB_PERF_EN
    ,
    .perf_writes (perf_writes),
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic drive_a(input logic v, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.a_valid = v;
    bus.a_addr  = addr;
    bus.a_data  = data;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.b_valid = v;
    bus.b_addr  = addr;
    bus.b_data  = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every RF write must match the oldest expected write
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.rf_wen === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_wen", bus.rf_wen, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("sb_waddr", bus.rf_waddr, e.addr);
        check("sb_wdata", bus.rf_wdata, e.data);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);

    // Reset state
    @(negedge clk);
    check("rst_a_ready", bus.a_ready, 1'b1);
    check("rst_b_ready", bus.b_ready, 1'b1);
    check("rst_wen",     bus.rf_wen,  1'b0);
    check("rst_idle",    bus.idle,    1'b1);
`ifdef RF_ARB_PERF_EN
    check("rst_perf_writes", perf_writes, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 1: single A write, written exactly one cycle after acceptance
    check("s1_a_ready", bus.a_ready, 1'b1);
    drive_a(1'b1, 5'd5, 32'h1111_1111);
    push(5'd5, 32'h1111_1111);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    check("s1_wen",   bus.rf_wen,   1'b1);
    check("s1_waddr", bus.rf_waddr, 5'd5);
    check("s1_wdata", bus.rf_wdata, 32'h1111_1111);
    @(negedge clk);
    check("s1_wen_after",  bus.rf_wen, 1'b0);
    check("s1_idle_after", bus.idle,   1'b1);

    // 2: write to x0 is accepted and dropped
    drive_a(1'b1, 5'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    check("s2_a_ready", bus.a_ready, 1'b1);
    check("s2_wen",     bus.rf_wen,  1'b0);
    check("s2_idle",    bus.idle,    1'b1);
    @(negedge clk);
    check("s2_wen_late", bus.rf_wen, 1'b0);
    check("s2_idle_late", bus.idle,  1'b1);

    // 3: same-cycle arrivals with rr = 0 after a fresh reset, then repeated
    do_reset();
    drive_a(1'b1, 5'd3, 32'h0000_000A);
    drive_b(1'b1, 5'd4, 32'h0000_000B);
    push(5'd3, 32'h0000_000A);
    push(5'd4, 32'h0000_000B);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    check("s3_first_addr", bus.rf_waddr, 5'd3);
    check("s3_b_ready",    bus.b_ready,  1'b0);
    check("s3_a_ready",    bus.a_ready,  1'b1);
    @(negedge clk);
    check("s3_second_wen",  bus.rf_wen,   1'b1);
    check("s3_second_addr", bus.rf_waddr, 5'd4);
    @(negedge clk);
    check("s3_idle", bus.idle, 1'b1);
`ifdef RF_ARB_PERF_EN
    check("s3_perf_writes", perf_writes, 32'd2);
    check("s3_perf_stalls", perf_stalls, 32'd1);
`endif
    drive_a(1'b1, 5'd3, 32'h0000_00A2);
    drive_b(1'b1, 5'd4, 32'h0000_00B2);
    push(5'd4, 32'h0000_00B2);
    push(5'd3, 32'h0000_00A2);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    check("s3r_first_addr", bus.rf_waddr, 5'd4);
    check("s3r_a_ready",    bus.a_ready,  1'b0);
    @(negedge clk);
    check("s3r_second_addr", bus.rf_waddr, 5'd3);
    @(negedge clk);
    check("s3r_idle", bus.idle, 1'b1);

    // 4: age ordering, the older held entry beats a later arrival
    drive_a(1'b1, 5'd1, 32'h0000_0101);
    drive_b(1'b1, 5'd2, 32'h0000_0202);
    push(5'd1, 32'h0000_0101);
    push(5'd2, 32'h0000_0202);
    push(5'd6, 32'h0000_0606);
    push(5'd7, 32'h0000_0707);
    @(negedge clk);
    check("s4_w1_addr", bus.rf_waddr, 5'd1);
    check("s4_a_ready", bus.a_ready,  1'b1);
    drive_a(1'b1, 5'd6, 32'h0000_0606);
    drive_b(1'b0, '0, '0);
    @(negedge clk);
    check("s4_w2_addr",      bus.rf_waddr, 5'd2);
    check("s4_a_ready_lose", bus.a_ready,  1'b0);
    check("s4_b_ready",      bus.b_ready,  1'b1);
    drive_a(1'b0, '0, '0);
    drive_b(1'b1, 5'd7, 32'h0000_0707);
    @(negedge clk);
    drive_b(1'b0, '0, '0);
    check("s4_w3_older_a", bus.rf_waddr, 5'd6);
    check("s4_b_ready_wait", bus.b_ready, 1'b0);
    @(negedge clk);
    check("s4_w4_addr", bus.rf_waddr, 5'd7);
    @(negedge clk);
    check("s4_idle", bus.idle, 1'b1);

    // 5: eight back-to-back A writes sustain one write per cycle
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) check("s5_wen_b2b", bus.rf_wen, 1'b1);
      check("s5_a_ready", bus.a_ready, 1'b1);
      if (i < 8) begin
        drive_a(1'b1, AW'(i + 11), 32'hC0DE_0000 + DW'(i));
        push(AW'(i + 11), 32'hC0DE_0000 + DW'(i));
      end else begin
        drive_a(1'b0, '0, '0);
      end
      @(negedge clk);
    end
    check("s5_wen_end", bus.rf_wen, 1'b0);
    check("s5_idle",    bus.idle,   1'b1);

    // 6: asynchronous reset with both slots occupied drops both entries
    drive_a(1'b1, 5'd9,  32'h9999_9999);
    drive_b(1'b1, 5'd10, 32'hAAAA_AAAA);
    @(posedge clk);
    #1;
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    check("s6_both_held", bus.idle, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("s6_async_wen",  bus.rf_wen, 1'b0);
    check("s6_async_idle", bus.idle,   1'b1);
    check("s6_async_a_ready", bus.a_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("s6_wen_after", bus.rf_wen, 1'b0);
    check("s6_idle_after", bus.idle,  1'b1);
`ifdef RF_ARB_PERF_EN
    check("s6_perf_writes", perf_writes, 32'd0);
`endif

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
